// File: rtl/ula_serial_12bits_pkg.sv
// ---------------------------------------------------------------------------
// ula_serial_12bits_pkg
// Shared definitions for the nibble-serial ULA:
//   - NIBBLE_W     : width of the reused ULA slice
//   - OP_*         : seletor opcodes
//   - state_t      : sequencing FSM states
// ---------------------------------------------------------------------------
package ula_serial_12bits_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/ula_serial_12bits_nibble.sv
// ---------------------------------------------------------------------------
// ula_nibble
// Combinational 4-bit ULA slice reused once per nibble by ula_serial_12bits.
// Ports:
//   a, b     : operand nibbles
//   cin      : carry into this nibble
//   seletor  : operation select (OP_* in the package)
//   y        : result nibble
//   cout     : nibble carry-out (ADD/SUB only, otherwise 0)
// ---------------------------------------------------------------------------
module ula_nibble
    import ula_serial_12bits_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic [2:0]          seletor,
    output logic [NIBBLE_W-1:0] y,
    output logic                cout
);

    logic [NIBBLE_W:0] sum;

    always_comb begin
        sum  = '0;
        y    = '0;
        cout = 1'b0;
        case (seletor)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
                y    = sum[NIBBLE_W-1:0];
                cout = sum[NIBBLE_W];
            end
            OP_SUB: begin
                sum  = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, cin};
                y    = sum[NIBBLE_W-1:0];
                cout = sum[NIBBLE_W];
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/ula_serial_12bits.sv
// ---------------------------------------------------------------------------
// ula_serial_12bits
// Nibble-serial W-bit ULA (W = 4*NIBBLES). One shared 4-bit slice processes
// one nibble per clock, carrying between nibbles through a register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request; accepted when idle or on the final-nibble edge
//   A, B       : operands (latched at accept)
//   carry_in   : initial carry (latched at accept)
//   seletor    : operation (latched at accept)
//   resultado  : result register, valid from done until next accept
//   carry_out  : carry out of the last nibble
//   busy       : operation in progress
//   done       : one-cycle pulse, resultado/carry_out valid
// ---------------------------------------------------------------------------
module ula_serial_12bits
    import ula_serial_12bits_pkg::*;
#(
    parameter int unsigned NIBBLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] A,
    input  logic [NIBBLE_W*NIBBLES-1:0] B,
    input  logic                        carry_in,
    input  logic [2:0]                  seletor,
    output logic [NIBBLE_W*NIBBLES-1:0] resultado,
    output logic                        carry_out,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           carry_reg;
    logic [W-1:0]   a_reg, b_reg;
    logic [2:0]     sel_reg;

    logic [NIBBLE_W-1:0] a_nib, b_nib, y_nib;
    logic                cout_nib;
    logic                last_nib;
    logic                accept;

    assign last_nib = (cnt == CW'(NIBBLES - 1));

    // Accepting on the final-nibble edge lets a held start sustain one
    // operation per NIBBLES cycles; start on the other CALC edges is ignored.
    assign accept = start && ((state == IDLE) || last_nib);

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    ula_nibble u_nibble (
        .a       (a_nib),
        .b       (b_nib),
        .cin     (carry_reg),
        .seletor (sel_reg),
        .y       (y_nib),
        .cout    (cout_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_nib && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sel_reg   <= '0;
            resultado <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == CALC) begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (cnt == CW'(i))
                        resultado[i*NIBBLE_W +: NIBBLE_W] <= y_nib;
                end
                carry_reg <= cout_nib;
                cnt       <= cnt + CW'(1);
                if (last_nib) begin
                    carry_out <= cout_nib;
                    done      <= 1'b1;
                end
            end
            // Later in the block so a new accept overrides the carry/counter
            // updates of the nibble just finished.
            if (accept) begin
                a_reg     <= A;
                b_reg     <= B;
                sel_reg   <= seletor;
                carry_reg <= carry_in;
                cnt       <= '0;
            end
        end
    end

    assign busy = (state == CALC);

endmodule
